// File: rtl/lsu_ctrl.sv
// Load/store sequencer: checks the access size and alignment, runs one request/grant/response
// bus transaction, and returns the lane-extracted, sign- or zero-extended load result.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req,
    input  logic        mem_wren,
    input  logic [2:0]  l_length,
    input  logic        l_unsigned,
    input  logic [1:0]  s_length,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        lsu_stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = DW / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    size_e            size_q, size_d;
    logic [1:0]       lane_q, lane_d;
    logic             uns_q, uns_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [DW-1:0]    bus_addr_q, bus_addr_d;
    logic [BEW-1:0]   bus_be_q, bus_be_d;
    logic [DW-1:0]    bus_wdata_q, bus_wdata_d;
    logic [DW-1:0]    ld_data_q, ld_data_d;
    logic             ld_valid_q, ld_valid_d;
    logic             bus_err_q, bus_err_d;
    logic             misalign_q, misalign_d;

    size_e            req_size;
    logic             req_legal;
    logic             req_aligned;
    logic [BEW-1:0]   req_be;
    logic [DW-1:0]    req_wdata;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [DW-1:0]    rd_ext;

    // Decode the incoming request: size, legality, alignment and bus lane layout.
    always_comb begin
        req_size  = SZ_B;
        req_legal = 1'b0;
        if (mem_wren) begin
            case (s_length)
                2'b00:   begin req_size = SZ_B; req_legal = 1'b1; end
                2'b01:   begin req_size = SZ_H; req_legal = 1'b1; end
                2'b10:   begin req_size = SZ_W; req_legal = 1'b1; end
                default: ;
            endcase
        end else begin
            case (l_length)
                3'b000, 3'b100: begin req_size = SZ_B; req_legal = 1'b1; end
                3'b001, 3'b101: begin req_size = SZ_H; req_legal = 1'b1; end
                3'b010:         begin req_size = SZ_W; req_legal = 1'b1; end
                default: ;
            endcase
        end

        req_aligned = 1'b1;
        req_be      = 4'b1111;
        req_wdata   = st_data;
        case (req_size)
            SZ_B: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                req_aligned = ~addr[0];
                req_be      = addr[1] ? 4'b1100 : 4'b0011;
                req_wdata   = {2{st_data[15:0]}};
            end
            default: req_aligned = (addr[1:0] == 2'b00);
        endcase
    end

    // Lane extraction and extension of the returned read word.
    always_comb begin
        byte_sel = bus_rdata[{lane_q, 3'b000} +: 8];
        half_sel = bus_rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    rd_ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    rd_ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: rd_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        lane_d      = lane_q;
        uns_d       = uns_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        ld_data_d   = ld_data_q;
        ld_valid_d  = 1'b0;
        bus_err_d   = 1'b0;
        misalign_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lsu_req && req_legal) begin
                    if (!req_aligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        size_d      = req_size;
                        lane_d      = addr[1:0];
                        uns_d       = l_unsigned;
                        bus_we_d    = mem_wren;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = req_be;
                        bus_wdata_d = req_wdata;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d = bus_we_q ? S_DONE : S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    ld_data_d  = rd_ext;
                    ld_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ld_data_d  = '0;
                    ld_valid_d = 1'b1;
                    bus_err_d  = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        bus_req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            size_q      <= SZ_B;
            lane_q      <= '0;
            uns_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            ld_data_q   <= '0;
            ld_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            uns_q       <= uns_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            ld_data_q   <= ld_data_d;
            ld_valid_q  <= ld_valid_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
        end
    end

    // Stall must rise in the accepting cycle so the PC holds before the request is issued.
    assign lsu_stall = ((state_q == S_IDLE) && lsu_req && req_legal && req_aligned)
                     || (state_q == S_REQ) || (state_q == S_WAIT);

    assign ld_data   = ld_data_q;
    assign ld_valid  = ld_valid_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
